rv32i_mem_stage: RTL and testbench

Parametrised successor to the plain MEM pipeline register of the RV32I core. It sits between the execute stage and the write-back stage. It passes non-memory instructions through with one cycle of latency, as the earlier stage did. It also executes loads and stores against a variable-latency data-memory port using a req/ack handshake, with byte-lane steering, load sign/zero extension, misalignment detection, a bus timeout, flush, and an upstream stall.

---
 rtl/rv32i_mem_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_rv32i_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_stage.sv
// rv32i_mem_stage: MEM pipeline stage of the RV32I core.
// Passes ALU results through and runs loads/stores on a req/ack data port.
module rv32i_mem_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       iw_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       rs2_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic              wb_en_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       iw_out,
    output logic [31:0]       alu_out,
    output logic              misalign_out,
    output logic              bus_err_out
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;

    logic [31:0] c_pc;
    logic [31:0] c_iw;
    logic [31:0] c_alu;
    logic [31:0] c_rs2;
    logic        c_wb;
    logic        c_flush;
    logic [15:0] cnt;

    logic        in_load;
    logic        in_store;
    logic        in_mem;
    logic        in_bad;

    logic        c_store;
    logic [2:0]  c_f3;
    logic [1:0]  c_off;
    logic        fl;
    logic        to_hit;
    logic [31:0] rsh;
    logic [31:0] ld_data;

    // Unsupported funct3 encodings are reported the same way as a bad offset.
    function automatic logic bad_access(
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic r;
        r = 1'b1;
        if (st) begin
            case (f3)
                3'd0:    r = 1'b0;
                3'd1:    r = off[0];
                3'd2:    r = |off;
                default: r = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: r = 1'b0;
                3'd1, 3'd5: r = off[0];
                3'd2:       r = |off;
                default:    r = 1'b1;
            endcase
        end
        return r;
    endfunction

    assign in_load  = (iw_in[6:0] == OP_LOAD);
    assign in_store = (iw_in[6:0] == OP_STORE);
    assign in_mem   = in_load | in_store;
    assign in_bad   = bad_access(in_store, iw_in[14:12], alu_in[1:0]);

    assign c_store  = (c_iw[6:0] == OP_STORE);
    assign c_f3     = c_iw[14:12];
    assign c_off    = c_alu[1:0];
    assign fl       = c_flush | flush;
    assign to_hit   = (cnt == TO_LAST);
    assign rsh      = mem_rdata >> {c_off, 3'b000};

    // Load data extraction: lane shift then sign/zero extension.
    always_comb begin
        ld_data = rsh;
        case (c_f3)
            3'd0:    ld_data = {{24{rsh[7]}}, rsh[7:0]};
            3'd1:    ld_data = {{16{rsh[15]}}, rsh[15:0]};
            3'd4:    ld_data = {24'h0, rsh[7:0]};
            3'd5:    ld_data = {16'h0, rsh[15:0]};
            default: ld_data = rsh;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bus-side outputs; the bus is idle outside BUSY.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        stall_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && !flush && in_mem && !in_bad) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_req   = 1'b1;
                mem_we    = c_store;
                mem_addr  = {c_alu[ADDR_W-1:2], 2'b00};
                stall_out = ~mem_ack;
                mem_be    = 4'b1111;
                mem_wdata = c_rs2;
                unique case (1'b1)
                    (c_store && c_f3 == 3'd0): begin
                        mem_wdata = {4{c_rs2[7:0]}};
                        mem_be    = 4'(4'b0001 << c_off);
                    end
                    (c_store && c_f3 == 3'd1): begin
                        mem_wdata = {2{c_rs2[15:0]}};
                        mem_be    = 4'(4'b0011 << c_off);
                    end
                    default: begin
                        mem_wdata = c_rs2;
                        mem_be    = 4'b1111;
                    end
                endcase
                if (mem_ack || to_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture registers, timeout counter and write-back outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_pc         <= '0;
            c_iw         <= '0;
            c_alu        <= '0;
            c_rs2        <= '0;
            c_wb         <= 1'b0;
            c_flush      <= 1'b0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            wb_en_out    <= 1'b0;
            pc_out       <= '0;
            iw_out       <= '0;
            alu_out      <= '0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    wb_en_out <= 1'b0;
                    if (in_valid && !flush) begin
                        misalign_out <= 1'b0;
                        bus_err_out  <= 1'b0;
                        if (!in_mem) begin
                            out_valid <= 1'b1;
                            wb_en_out <= wb_en_in;
                            pc_out    <= pc_in;
                            iw_out    <= iw_in;
                            alu_out   <= alu_in;
                        end else if (in_bad) begin
                            out_valid    <= 1'b1;
                            misalign_out <= 1'b1;
                            pc_out       <= pc_in;
                            iw_out       <= iw_in;
                            alu_out      <= alu_in;
                        end else begin
                            c_pc    <= pc_in;
                            c_iw    <= iw_in;
                            c_alu   <= alu_in;
                            c_rs2   <= rs2_in;
                            c_wb    <= wb_en_in;
                            c_flush <= 1'b0;
                            cnt     <= '0;
                        end
                    end
                end
                BUSY: begin
                    out_valid <= 1'b0;
                    wb_en_out <= 1'b0;
                    if (flush) begin
                        c_flush <= 1'b1;
                    end
                    if (mem_ack) begin
                        out_valid <= ~fl;
                        pc_out    <= c_pc;
                        iw_out    <= c_iw;
                        if (c_store) begin
                            alu_out <= c_alu;
                        end else begin
                            alu_out   <= ld_data;
                            wb_en_out <= c_wb & ~fl;
                        end
                    end else if (to_hit) begin
                        out_valid   <= ~fl;
                        bus_err_out <= 1'b1;
                        pc_out      <= c_pc;
                        iw_out      <= c_iw;
                        alu_out     <= c_alu;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    wb_en_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// tb_rv32i_mem_stage: directed bench for rv32i_mem_stage.
// Expected write-back results are queued at issue and popped on out_valid.
module tb_rv32i_mem_stage;

    localparam int TO = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        flush;
    logic        wb_en_in;
    logic [31:0] pc_in;
    logic [31:0] iw_in;
    logic [31:0] alu_in;
    logic [31:0] rs2_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        wb_en_out;
    logic [31:0] pc_out;
    logic [31:0] iw_out;
    logic [31:0] alu_out;
    logic        misalign_out;
    logic        bus_err_out;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] iw;
        logic [31:0] alu;
        logic        wb;
        logic        mis;
        logic        berr;
        logic        chk_alu;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    rv32i_mem_stage #(
        .ADDR_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .flush       (flush),
        .wb_en_in    (wb_en_in),
        .pc_in       (pc_in),
        .iw_in       (iw_in),
        .alu_in      (alu_in),
        .rs2_in      (rs2_in),
        .stall_out   (stall_out),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .wb_en_out   (wb_en_out),
        .pc_out      (pc_out),
        .iw_out      (iw_out),
        .alu_out     (alu_out),
        .misalign_out(misalign_out),
        .bus_err_out (bus_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'd3, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] iw,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic wb);
        pc_in    = pc;
        iw_in    = iw;
        alu_in   = alu;
        rs2_in   = rs2;
        wb_en_in = wb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] iw,
                        input logic [31:0] alu, input logic wb, input logic mis,
                        input logic berr, input logic ca);
        exp_t e;
        e.pc = pc; e.iw = iw; e.alu = alu; e.wb = wb;
        e.mis = mis; e.berr = berr; e.chk_alu = ca;
        exp_q.push_back(e);
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        if (out_valid !== 1'b1) begin
            chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".pc"}, pc_out, e.pc);
        chk({tag, ".iw"}, iw_out, e.iw);
        chk({tag, ".wb"}, 32'(wb_en_out), 32'(e.wb));
        chk({tag, ".mis"}, 32'(misalign_out), 32'(e.mis));
        chk({tag, ".berr"}, 32'(bus_err_out), 32'(e.berr));
        if (e.chk_alu) chk({tag, ".alu"}, alu_out, e.alu);
    endtask

    task automatic run_ack(input int k, input logic [31:0] rd, output int stalls);
        stalls = 0;
        for (int i = 1; i <= k; i++) begin
            if (i == k) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            #1;
            if (stall_out === 1'b1) stalls++;
            step();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
    endtask

    initial begin
        int st;
        int req;
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        wb_en_in  = 1'b0;
        pc_in     = '0;
        iw_in     = '0;
        alu_in    = '0;
        rs2_in    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        step();
        step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.stall", 32'(stall_out), 32'd0);
        chk("rst.mem_be", 32'(mem_be), 32'd0);
        chk("rst.alu_out", alu_out, 32'd0);
        chk("rst.pc_out", pc_out, 32'd0);
        reset = 1'b0;

        issue(32'h80, mk(3'd2, OP_LOAD), 32'h3000, 32'h0, 1'b1);
        chk("rstbusy.req_before", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstbusy.mem_req", 32'(mem_req), 32'd0);
        chk("rstbusy.stall", 32'(stall_out), 32'd0);
        chk("rstbusy.out_valid", 32'(out_valid), 32'd0);
        chk("rstbusy.mem_be", 32'(mem_be), 32'd0);
        chk("rstbusy.alu_out", alu_out, 32'd0);
        step();
        chk("rstbusy.req_later", 32'(mem_req), 32'd0);

        issue(32'h100, mk(3'd0, OP_ALU), 32'h55, 32'h0, 1'b1);
        push(32'h100, mk(3'd0, OP_ALU), 32'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("add.stall", 32'(stall_out), 32'd0);
        chk("add.req", 32'(mem_req), 32'd0);
        expect_out("add");
        step();
        chk("add.drop", 32'(out_valid), 32'd0);

        issue(32'h200, mk(3'd0, OP_LOAD), 32'h1003, 32'h0, 1'b1);
        push(32'h200, mk(3'd0, OP_LOAD), 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lb.addr", mem_addr, 32'h1000);
        chk("lb.we", 32'(mem_we), 32'd0);
        chk("lb.be", 32'(mem_be), 32'hF);
        chk("lb.valid_busy", 32'(out_valid), 32'd0);
        run_ack(3, 32'h80AABBCC, st);
        chk("lb.stalls", 32'(st), 32'd2);
        expect_out("lb");

        issue(32'h204, mk(3'd4, OP_LOAD), 32'h1003, 32'h0, 1'b1);
        push(32'h204, mk(3'd4, OP_LOAD), 32'h00000080, 1'b1, 1'b0, 1'b0, 1'b1);
        run_ack(3, 32'h80AABBCC, st);
        expect_out("lbu");

        issue(32'h208, mk(3'd1, OP_STORE), 32'h2002, 32'h1234ABCD, 1'b1);
        push(32'h208, mk(3'd1, OP_STORE), 32'h2002, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sh.be", 32'(mem_be), 32'hC);
        chk("sh.wdata", mem_wdata, 32'hABCDABCD);
        chk("sh.we", 32'(mem_we), 32'd1);
        chk("sh.addr", mem_addr, 32'h2000);
        run_ack(1, 32'h0, st);
        chk("sh.stalls", 32'(st), 32'd0);
        expect_out("sh");

        issue(32'h20C, mk(3'd2, OP_LOAD), 32'h2001, 32'h0, 1'b1);
        push(32'h20C, mk(3'd2, OP_LOAD), 32'h2001, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("lwmis.req", 32'(mem_req), 32'd0);
        expect_out("lwmis");

        issue(32'h20E, mk(3'd3, OP_LOAD), 32'h6000, 32'h0, 1'b1);
        push(32'h20E, mk(3'd3, OP_LOAD), 32'h6000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("badf3.req", 32'(mem_req), 32'd0);
        expect_out("badf3");

        issue(32'h210, mk(3'd2, OP_LOAD), 32'h4000, 32'h0, 1'b1);
        push(32'h210, mk(3'd2, OP_LOAD), 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        req = 0;
        for (int i = 0; i < 10 && mem_req === 1'b1; i++) begin
            req++;
            step();
        end
        chk("to.req_cycles", 32'(req), 32'd4);
        expect_out("to");
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        #1;
        chk("to.late_stall", 32'(stall_out), 32'd0);
        step();
        mem_ack   = 1'b0;
        chk("to.late_valid", 32'(out_valid), 32'd0);
        chk("to.late_req", 32'(mem_req), 32'd0);

        issue(32'h214, mk(3'd2, OP_STORE), 32'h5000, 32'hDEADBEEF, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl.req", 32'(mem_req), 32'd1);
        chk("fl.we", 32'(mem_we), 32'd1);
        chk("fl.wdata", mem_wdata, 32'hDEADBEEF);
        chk("fl.be", 32'(mem_be), 32'hF);
        mem_ack = 1'b1;
        #1;
        chk("fl.stall_ack", 32'(stall_out), 32'd0);
        step();
        mem_ack = 1'b0;
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.wb", 32'(wb_en_out), 32'd0);
        chk("fl.req_after", 32'(mem_req), 32'd0);
        step();
        chk("fl.valid2", 32'(out_valid), 32'd0);

        issue(32'h300, mk(3'd0, OP_ALU), 32'h77, 32'h0, 1'b1);
        push(32'h300, mk(3'd0, OP_ALU), 32'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("add2");
        chk("sb.empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
